internal_ram_bridge: RTL

- Bus-side initiator for the on-chip RAM port (`en`/`wr`/`addr[10:0]`/`mask[7:0]`/`wrData[63:0]`/`rdData[63:0]`, 1-cycle read latency, lower 8 KB ROM).
- Accepts 32-bit byte-addressed commands on a valid/ready stream and drives the 64-bit RAM port with the correct half-word lanes.
- Tracks in-flight accesses and returns exactly one response per command through a response FIFO with backpressure.
- Sits between the CPU-side data/instruction bus and the RAM.

---
 rtl/internal_ram_bridge_if.sv | 48 ++++
 rtl/internal_ram_bridge.sv | 119 +++++++++++
 2 files changed

// File: rtl/internal_ram_bridge_if.sv
`timescale 1ns/1ps
// internal_ram_bridge_if
// Bundles the three signal groups around the RAM bridge:
//   cmd_*  : valid/ready command stream from the CPU-side bus (32-bit, byte addressed)
//   rsp_*  : valid/ready response stream back to the CPU-side bus
//   ram_*  : 64-bit on-chip RAM port (1-cycle read latency)
// Modports:
//   master : the CPU side plus the RAM itself (drives commands, consumes responses,
//            supplies ram_rdData)
//   slave  : the bridge (accepts commands, produces responses, drives the RAM port)
interface internal_ram_bridge_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [13:0] cmd_address;
  logic [31:0] cmd_data;
  logic [3:0]  cmd_mask;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_error;

  logic        ram_en;
  logic        ram_wr;
  logic [10:0] ram_addr;
  logic [7:0]  ram_mask;
  logic [63:0] ram_wrData;
  logic [63:0] ram_rdData;

  modport master (
    output cmd_valid, cmd_write, cmd_address, cmd_data, cmd_mask,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_error,
    output rsp_ready,
    input  ram_en, ram_wr, ram_addr, ram_mask, ram_wrData,
    output ram_rdData
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_address, cmd_data, cmd_mask,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_error,
    input  rsp_ready,
    output ram_en, ram_wr, ram_addr, ram_mask, ram_wrData,
    input  ram_rdData
  );
endinterface

// File: rtl/internal_ram_bridge.sv
`timescale 1ns/1ps
// internal_ram_bridge
// Bus-side initiator for the on-chip RAM. Turns 32-bit byte-addressed commands into
// accesses on the 64-bit RAM port (selecting the correct half-word lanes), captures
// the read data one cycle later and returns exactly one in-order response per
// command through a small response FIFO with backpressure.
//
// Ports:
//   clk    : single clock, rising edge
//   reset  : asynchronous, active-high reset
//   bus    : internal_ram_bridge_if.slave (cmd_*, rsp_*, ram_* groups)
// Parameter:
//   RSP_DEPTH : response FIFO entries (power of 2, >= 2)
// Optional feature:
//   ROM_WRITE_ERROR_EN : when defined, writes to the lower 8 KB ROM region are not
//                        issued to the RAM and are answered with rsp_error=1.
module internal_ram_bridge #(
  parameter int RSP_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  internal_ram_bridge_if.slave bus
);

  localparam int PtrW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CntW = PtrW + 1;

  logic            fire;
  logic            blocked;
  logic            push;
  logic            pop;
  logic            cmdReady_q;
  logic            cmdReady_d;
  logic            inflight_q;
  logic            half_q;
  logic            isWrite_q;
  logic            err_q;
  logic [PtrW-1:0] wrPtr_q;
  logic [PtrW-1:0] rdPtr_q;
  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;
  logic [CntW:0]   creditUse;
  logic [31:0]     pushData;
  logic [32:0]     rspMem_q [RSP_DEPTH];
  logic [32:0]     headEntry;
  logic            unusedAddrBits;

  // Word-aligned commands: the two lowest byte-address bits carry no information.
  assign unusedAddrBits = ^bus.cmd_address[1:0];

`ifdef ROM_WRITE_ERROR_EN
  // Writes into the lower 8 KB are ROM writes; keep them off the RAM port.
  assign blocked = bus.cmd_write & ~bus.cmd_address[13];
`else
  assign blocked = 1'b0;
`endif

  assign fire = bus.cmd_valid & cmdReady_q;

  // RAM port is driven straight from the command; the 32-bit data is replicated
  // onto both halves and the byte mask steers the write into the addressed half.
  assign bus.ram_en     = fire & ~blocked;
  assign bus.ram_wr     = bus.cmd_write;
  assign bus.ram_addr   = bus.cmd_address[13:3];
  assign bus.ram_wrData = {bus.cmd_data, bus.cmd_data};
  assign bus.ram_mask   = bus.cmd_address[2] ? {bus.cmd_mask, 4'b0000}
                                             : {4'b0000, bus.cmd_mask};

  // The in-flight stage lines up with the RAM's read data, so the push happens
  // exactly one cycle after the access.
  assign push     = inflight_q;
  assign pushData = (isWrite_q | err_q) ? 32'h0
                  : (half_q ? bus.ram_rdData[63:32] : bus.ram_rdData[31:0]);

  assign pop     = (count_q != '0) & bus.rsp_ready;
  assign count_d = count_q + CntW'(push) - CntW'(pop);

  // A credit is held by every queued entry and by the access still in flight,
  // so the FIFO can never be overrun even with rsp_ready held low.
  assign creditUse  = {1'b0, count_d} + (CntW+1)'(fire);
  assign cmdReady_d = creditUse < (CntW+1)'(RSP_DEPTH);

  // Control state: credit flag, in-flight stage, FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmdReady_q <= 1'b0;
      inflight_q <= 1'b0;
      half_q     <= 1'b0;
      isWrite_q  <= 1'b0;
      err_q      <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
    end else begin
      cmdReady_q <= cmdReady_d;
      inflight_q <= fire;
      if (fire) begin
        half_q    <= bus.cmd_address[2];
        isWrite_q <= bus.cmd_write;
        err_q     <= blocked;
      end
      if (push) wrPtr_q <= wrPtr_q + PtrW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Response storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) rspMem_q[wrPtr_q] <= {pushData, err_q};
  end

  assign headEntry     = rspMem_q[rdPtr_q];
  assign bus.rsp_valid = (count_q != '0);
  assign bus.rsp_data  = bus.rsp_valid ? headEntry[32:1] : 32'h0;
  assign bus.rsp_error = bus.rsp_valid & headEntry[0];
  assign bus.cmd_ready = cmdReady_q;

endmodule
